// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  localparam int RESOLUTION_DEF = 32;
  localparam int GATE_LOG2_DEF  = 20;
  localparam int SHIFT          = RESOLUTION_DEF - GATE_LOG2_DEF;

  // Left shift that turns an edge count over 2^gate_log2 cycles into a tuning word.
  function automatic int shift_of(input int resolution, input int gate_log2);
    return resolution - gate_log2;
  endfunction
endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of the frequency meter.
interface freq_meter_if #(parameter int RESOLUTION = 32);
  logic                  start;
  logic                  continuous;
  logic [RESOLUTION-1:0] frequency;
  logic                  valid;
  logic                  busy;
  logic                  no_signal;

  modport master (output start, continuous, input frequency, valid, busy, no_signal);
  modport slave  (input start, continuous, output frequency, valid, busy, no_signal);
endinterface

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse for an async input.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);
  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      prev  <= s2;
      pulse <= s2 & ~prev;
    end
  end
endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter; result is a phase-accumulator tuning word.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int RESOLUTION = 32,
  parameter int GATE_LOG2  = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);
  localparam int SH = shift_of(RESOLUTION, GATE_LOG2);

  state_t                 state, state_n;
  logic [GATE_LOG2-1:0]   gcnt, ecnt, ecnt_fin;
  logic [RESOLUTION-1:0]  freq_q;
  logic                   valid_q, nosig_q;
  logic                   edge_p, gate_tc;

  edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sig_in),
    .pulse (edge_p)
  );

  assign gate_tc  = &gcnt;
  // An edge landing on the final gate cycle still belongs to this gate.
  assign ecnt_fin = ecnt + {{(GATE_LOG2-1){1'b0}}, edge_p};

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.start || bus.continuous) state_n = ARM;
      ARM:  if (edge_p) state_n = GATE;
            else if (gate_tc) state_n = DONE;
      GATE: if (gate_tc) state_n = DONE;
      DONE: state_n = bus.continuous ? ARM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gcnt    <= '0;
      ecnt    <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      nosig_q <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= (state_n == DONE);
      case (state)
        ARM: begin
          // The aligning edge restarts both counters and is not itself counted.
          if (edge_p) begin
            gcnt <= '0;
            ecnt <= '0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        GATE: begin
          gcnt <= gcnt + 1'b1;
          if (edge_p) ecnt <= ecnt + 1'b1;
        end
        default: begin
          gcnt <= '0;
          ecnt <= '0;
        end
      endcase
      if (state_n == DONE) begin
        nosig_q <= (state == ARM);
        freq_q  <= (state == ARM) ? '0 : ({{SH{1'b0}}, ecnt_fin} << SH);
      end
    end
  end

  assign bus.frequency = freq_q;
  assign bus.valid     = valid_q;
  assign bus.no_signal = nosig_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter at RESOLUTION=32, GATE_LOG2=8.
module tb_freq_meter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sig_in = 1'b0;
  int   half = 0;
  int   ph = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  freq_meter_if #(.RESOLUTION(32)) bus ();

  freq_meter #(.RESOLUTION(32), .GATE_LOG2(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Square wave with a half period of 'half' clk cycles; 0 holds it low.
  always @(negedge clk) begin
    if (half == 0) begin
      sig_in = 1'b0;
      ph = 0;
    end else if (ph + 1 >= half) begin
      sig_in = ~sig_in;
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!bus.valid && n < budget);
    if (!bus.valid) chk({tag, "_timeout"}, 64'(bus.valid), 64'd1);
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus.valid) cnt++;
    end
  endtask

  task automatic one_shot(input string tag, input logic [31:0] exp);
    int n;
    pulse_start();
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_valid(tag, 1000, n);
    chk({tag, "_freq"}, 64'(bus.frequency), 64'(exp));
    chk({tag, "_nosig"}, 64'(bus.no_signal), 64'd0);
    tick(1);
    chk({tag, "_vpulse"}, 64'(bus.valid), 64'd0);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n, cnt, g;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("rst_freq", 64'(bus.frequency), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_nosig", 64'(bus.no_signal), 64'd0);

    // period 16 -> 16 edges in 256 cycles
    half = 8; tick(40);
    one_shot("p16", 32'h1000_0000);

    // period 2 -> 128 edges
    half = 1; tick(20);
    one_shot("p2", 32'h8000_0000);

    // no signal: 1 + 256 + 1 cycles counting the start cycle
    half = 0; tick(10);
    pulse_start();
    wait_valid("nosig", 1000, n);
    chk("nosig_lat", 64'(n + 2), 64'd258);
    chk("nosig_freq", 64'(bus.frequency), 64'd0);
    chk("nosig_flag", 64'(bus.no_signal), 64'd1);
    tick(5);
    chk("nosig_hold", 64'(bus.no_signal), 64'd1);
    half = 16; tick(40);
    one_shot("p32", 32'h0800_0000);

    // continuous, period 8: gap = 256 gate + DONE + 7 ARM
    half = 4; tick(20);
    bus.continuous = 1'b1;
    wait_valid("cont0", 1000, n);
    chk("cont0_freq", 64'(bus.frequency), 64'h2000_0000);
    wait_valid("cont1", 1000, g);
    chk("cont1_freq", 64'(bus.frequency), 64'h2000_0000);
    chk("cont_gap", 64'(g), 64'd264);
    wait_valid("cont2", 1000, g);
    chk("cont2_freq", 64'(bus.frequency), 64'h2000_0000);
    tick(1);
    bus.continuous = 1'b0;
    wait_valid("cont_last", 1000, n);
    chk("cont_last_freq", 64'(bus.frequency), 64'h2000_0000);
    tick(1);
    chk("cont_idle", 64'(bus.busy), 64'd0);
    count_valid(600, cnt);
    chk("cont_extra", 64'(cnt), 64'd0);

    // reset 100 cycles into GATE (ARM is at most ~20 cycles at period 16)
    half = 8; tick(20);
    pulse_start();
    tick(120);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mrst_freq", 64'(bus.frequency), 64'd0);
    chk("mrst_valid", 64'(bus.valid), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_nosig", 64'(bus.no_signal), 64'd0);
    count_valid(400, cnt);
    chk("mrst_novalid", 64'(cnt), 64'd0);
    one_shot("after_rst", 32'h1000_0000);

    // start during GATE must be ignored
    pulse_start();
    tick(150);
    pulse_start();
    wait_valid("ign", 1000, n);
    chk("ign_freq", 64'(bus.frequency), 64'h1000_0000);
    count_valid(600, cnt);
    chk("ign_extra", 64'(cnt), 64'd0);
    chk("ign_idle", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
